ddr_rd_stream: RTL and testbench

Burst-read front end that turns one read command (start address, beat count) into a sequence of DDR read bursts and delivers the returned data as a single ordered valid/ready beat stream. It sits directly upstream of the dbuf loader and drives one `ddrN_data`/`ddrN_valid`/`ddrN_ready` input pair. Two instances feed the two loader stream ports. An internal FIFO plus credit accounting means read data is never stalled on the DDR side.

---
 rtl/ddr_rd_stream_pkg.sv | 18 +
 rtl/ddr_rd_fifo.sv | 47 ++++
 rtl/ddr_rd_stream.sv | 135 +++++++++++++
 tb/tb_ddr_rd_stream.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_rd_stream_pkg.sv
// Shared types and constants for the DDR burst-read front end.
// No logic; beat width and bit-width helper reused by every file.
// No flow control of its own.
package ddr_rd_stream_pkg;

  localparam int DDR_W = 512;

  function automatic int bw(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

endpackage

// File: rtl/ddr_rd_fifo.sv
// First-word-fall-through return FIFO holding DDR read beats.
// Latency: a write at cycle t is visible on rd_data/!empty at t+1.
// Backpressure: writes while full are dropped; upstream credit accounting keeps that from happening.
module ddr_rd_fifo
  import ddr_rd_stream_pkg::*;
#(
  parameter int W     = DDR_W,
  parameter int DEPTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [W-1:0]            wr_data,
  input  logic                    rd_en,
  output logic [W-1:0]            rd_data,
  output logic [bw(DEPTH)-1:0]    count,
  output logic                    empty,
  output logic                    full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // Extra pointer bit distinguishes full from empty.
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full)  wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ddr_rd_stream.sv
// Splits a read command into DDR bursts and streams returned beats in order (DDR_RD_4K_SPLIT_EN: no burst crosses 4 KB).
// Latency: first AR one cycle after command accept; r beat at t appears on st at t+1; done registered.
// Backpressure: st_ready stalls the FIFO; AR issue is gated by free credit so r_ready can stay high.
module ddr_rd_stream
  import ddr_rd_stream_pkg::*;
#(
  parameter int AXI_AW     = 32,
  parameter int LEN_W      = 16,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [AXI_AW-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              done,
  output logic              ar_valid,
  input  logic              ar_ready,
  output logic [AXI_AW-1:0] ar_addr,
  output logic [7:0]        ar_len,
  input  logic [DDR_W-1:0]  r_data,
  input  logic              r_valid,
  output logic              r_ready,
  output logic [DDR_W-1:0]  st_data,
  output logic              st_valid,
  input  logic              st_ready
);

  localparam int BEAT_B = DDR_W / 8;
  localparam int CW     = bw(FIFO_DEPTH);
  localparam int BLW    = LEN_W + 1;
  localparam logic [BLW-1:0] MAXB = BLW'(MAX_BURST);

  rd_state_t         state_q, state_d;
  logic [AXI_AW-1:0] cur_addr;
  logic [LEN_W-1:0]  req_left, out_left;
  logic [CW-1:0]     reserved, fifo_count, free_credit;
  logic [BLW-1:0]    blen;
  logic              fifo_empty, fifo_full;
  logic              done_q, done_d, r_rdy_q;
  logic              cmd_hs, ar_hs, r_hs, st_hs;

  always_comb begin
    blen = ({1'b0, req_left} > MAXB) ? MAXB : {1'b0, req_left};
`ifdef DDR_RD_4K_SPLIT_EN
    begin
      logic [BLW-1:0] room;
      room = BLW'((13'd4096 - {1'b0, cur_addr[11:0]}) >> $clog2(BEAT_B));
      if (room < blen) blen = room;
    end
`endif
  end

  assign free_credit = CW'(FIFO_DEPTH) - fifo_count - reserved;
  assign cmd_ready   = (state_q == IDLE);
  assign ar_valid    = (state_q == REQ) && (BLW'(free_credit) >= blen);
  assign ar_addr     = cur_addr;
  assign ar_len      = (state_q == REQ) ? 8'(blen - BLW'(1)) : 8'd0;
  assign r_ready     = r_rdy_q;
  assign st_valid    = !fifo_empty;
  assign done        = done_q;

  assign cmd_hs = cmd_valid && cmd_ready;
  assign ar_hs  = ar_valid && ar_ready;
  assign r_hs   = r_valid && r_rdy_q;
  assign st_hs  = st_valid && st_ready;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // A zero-length command completes without ever leaving IDLE.
        if (cmd_valid) begin
          state_d = (cmd_len == '0) ? IDLE : REQ;
          done_d  = (cmd_len == '0);
        end
      end
      REQ:   if (ar_hs && ({1'b0, req_left} == blen)) state_d = DRAIN;
      DRAIN: begin
        if (st_hs && (out_left == LEN_W'(1))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      r_rdy_q  <= 1'b0;
      cur_addr <= '0;
      req_left <= '0;
      out_left <= '0;
      reserved <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      r_rdy_q  <= 1'b1;
      reserved <= reserved + (ar_hs ? CW'(blen) : CW'(0)) - CW'(r_hs);
      if (cmd_hs) begin
        cur_addr <= cmd_addr;
        req_left <= cmd_len;
      end else if (ar_hs) begin
        cur_addr <= cur_addr + (AXI_AW'(blen) << $clog2(BEAT_B));
        req_left <= req_left - blen[LEN_W-1:0];
      end
      if (cmd_hs)     out_left <= cmd_len;
      else if (st_hs) out_left <= out_left - LEN_W'(1);
    end
  end

  ddr_rd_fifo #(.W(DDR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (r_hs),
    .wr_data (r_data),
    .rd_en   (st_ready),
    .rd_data (st_data),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

`ifndef SYNTHESIS
  a_no_overrun: assert property (@(posedge clk) disable iff (!rst) !(r_valid && fifo_full))
    else $error("ddr_rd_stream: read beat arrived while return FIFO full");
`endif

endmodule

// File: tb/tb_ddr_rd_stream.sv
// Directed bench for ddr_rd_stream with a fixed-latency in-order DDR responder.
module tb_ddr_rd_stream;
  import ddr_rd_stream_pkg::*;

  localparam int LAT = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready, done;
  logic [31:0]       cmd_addr;
  logic [15:0]       cmd_len;
  logic              ar_valid, ar_ready;
  logic [31:0]       ar_addr;
  logic [7:0]        ar_len;
  logic [DDR_W-1:0]  r_data;
  logic              r_valid, r_ready;
  logic [DDR_W-1:0]  st_data;
  logic              st_valid, st_ready;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int outstanding = 0, max_out = 0, done_cnt = 0;
  logic [31:0]      ar_a[$];
  int               ar_l[$];
  int               ar_c[$];
  logic [DDR_W-1:0] got[$];
  logic [31:0]      rq_addr[$];
  int               rq_due[$];
  logic [31:0]      ex[$];

  ddr_rd_stream dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .done(done),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
    .r_data(r_data), .r_valid(r_valid), .r_ready(r_ready),
    .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DDR_W-1:0] pat(input logic [31:0] a);
    return {(DDR_W/32){a}};
  endfunction

  // Handshake observer, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      rq_addr.delete();
      rq_due.delete();
      outstanding = 0;
    end else begin
      if (ar_valid && ar_ready) begin
        ar_a.push_back(ar_addr);
        ar_l.push_back(int'(ar_len));
        ar_c.push_back(cyc);
        for (int i = 0; i <= int'(ar_len); i++) begin
          rq_addr.push_back(ar_addr + 32'(i * (DDR_W/8)));
          rq_due.push_back(cyc + LAT);
        end
        outstanding += int'(ar_len) + 1;
      end
      if (r_valid && r_ready && rq_addr.size() > 0) begin
        void'(rq_addr.pop_front());
        void'(rq_due.pop_front());
      end
      if (st_valid && st_ready) begin
        got.push_back(st_data);
        outstanding -= 1;
      end
      if (outstanding > max_out) max_out = outstanding;
      if (done) done_cnt++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst && rq_addr.size() > 0 && rq_due[0] <= cyc) begin
      r_valid = 1'b1;
      r_data  = pat(rq_addr[0]);
    end else begin
      r_valid = 1'b0;
      r_data  = '0;
    end
  end

  task automatic chk(input string tag, input logic [DDR_W-1:0] obs, input logic [DDR_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    ar_a.delete(); ar_l.delete(); ar_c.delete(); got.delete(); ex.delete();
    max_out  = 0;
    done_cnt = 0;
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [15:0] l, output int acc, output logic dn);
    acc = -1;
    dn  = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
    for (int i = 0; i < 400 && acc < 0; i++) begin
      @(negedge clk);
      if (cmd_ready) begin acc = cyc; dn = done; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("cmd_accepted", DDR_W'(acc >= 0), DDR_W'(1));
  endtask

  task automatic wait_done(input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_seen", DDR_W'(seen), DDR_W'(1));
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_ar(input int idx, input logic [31:0] a, input int l);
    if (idx < ar_a.size()) begin
      chk($sformatf("ar%0d_addr", idx), DDR_W'(ar_a[idx]), DDR_W'(a));
      chk($sformatf("ar%0d_len", idx), DDR_W'(ar_l[idx]), DDR_W'(l));
    end else begin
      chk($sformatf("ar%0d_present", idx), DDR_W'(ar_a.size()), DDR_W'(idx + 1));
    end
  endtask

  task automatic add_exp(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) ex.push_back(base + 32'(i * (DDR_W/8)));
  endtask

  task automatic chk_stream(input string tag);
    int nb;
    nb = 0;
    chk({tag, "_beats"}, DDR_W'(got.size()), DDR_W'(ex.size()));
    for (int i = 0; i < ex.size() && i < got.size(); i++)
      if (got[i] !== pat(ex[i])) nb++;
    chk({tag, "_bad_data"}, DDR_W'(nb), DDR_W'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   acc_a, acc_b;
    logic dn_a, dn_b;
    rst = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; st_ready = 1'b0;

    #3;
    chk("rst_cmd_ready", DDR_W'(cmd_ready), DDR_W'(1));
    chk("rst_done",      DDR_W'(done),      DDR_W'(0));
    chk("rst_ar_valid",  DDR_W'(ar_valid),  DDR_W'(0));
    chk("rst_ar_addr",   DDR_W'(ar_addr),   DDR_W'(0));
    chk("rst_ar_len",    DDR_W'(ar_len),    DDR_W'(0));
    chk("rst_st_valid",  DDR_W'(st_valid),  DDR_W'(0));
    chk("rst_r_ready",   DDR_W'(r_ready),   DDR_W'(0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    wait_n(2);
    chk("r_ready_after_rst", DDR_W'(r_ready), DDR_W'(1));

    // Basic split into 16/16/8 bursts.
    ar_ready = 1'b1; st_ready = 1'b1;
    clear_logs();
    send_cmd(32'h0001_0000, 16'd40, acc_a, dn_a);
    wait_done(500);
    wait_n(5);
    chk("basic_done_count", DDR_W'(done_cnt), DDR_W'(1));
    chk("basic_ar_count", DDR_W'(ar_a.size()), DDR_W'(3));
    chk_ar(0, 32'h0001_0000, 15);
    chk_ar(1, 32'h0001_0400, 15);
    chk_ar(2, 32'h0001_0800, 7);
    if (ar_c.size() > 0) chk("basic_first_ar_cycle", DDR_W'(ar_c[0]), DDR_W'(acc_a + 1));
    add_exp(32'h0001_0000, 40);
    chk_stream("basic");

    // Command held while busy is only taken in the done cycle.
    clear_logs();
    send_cmd(32'h0002_0000, 16'd2, acc_a, dn_a);
    send_cmd(32'h0003_0000, 16'd3, acc_b, dn_b);
    chk("busy_accept_in_done_cycle", DDR_W'(dn_b), DDR_W'(1));
    wait_done(300);
    wait_n(3);
    chk("busy_ar_count", DDR_W'(ar_a.size()), DDR_W'(2));
    chk_ar(0, 32'h0002_0000, 1);
    chk_ar(1, 32'h0003_0000, 2);
    if (ar_c.size() > 1) chk("busy_second_ar_cycle", DDR_W'(ar_c[1]), DDR_W'(acc_b + 1));
    add_exp(32'h0002_0000, 2);
    add_exp(32'h0003_0000, 3);
    chk_stream("busy");

    // Stalled stream: credit caps outstanding beats at FIFO depth.
    clear_logs();
    st_ready = 1'b0;
    send_cmd(32'h0004_0000, 16'd100, acc_a, dn_a);
    wait_n(200);
    chk("bp_stalled_beats", DDR_W'(got.size()), DDR_W'(0));
    chk("bp_stalled_ars", DDR_W'(ar_a.size()), DDR_W'(2));
    chk("bp_stalled_outstanding", DDR_W'(outstanding), DDR_W'(32));
    @(posedge clk); #1 st_ready = 1'b1;
    wait_done(1000);
    wait_n(3);
    chk("bp_ar_count", DDR_W'(ar_a.size()), DDR_W'(7));
    chk_ar(6, 32'h0004_1800, 3);
    chk("bp_max_outstanding_le_32", DDR_W'(max_out <= 32), DDR_W'(1));
    add_exp(32'h0004_0000, 100);
    chk_stream("bp");

    // Zero length completes at once with no request.
    clear_logs();
    send_cmd(32'h0005_0000, 16'd0, acc_a, dn_a);
    @(negedge clk);
    chk("zero_done", DDR_W'(done), DDR_W'(1));
    chk("zero_cmd_ready", DDR_W'(cmd_ready), DDR_W'(1));
    wait_n(5);
    chk("zero_ar_count", DDR_W'(ar_a.size()), DDR_W'(0));
    chk("zero_done_count", DDR_W'(done_cnt), DDR_W'(1));

    // Burst straddling a 4 KB line.
    clear_logs();
    send_cmd(32'h0000_0FC0, 16'd4, acc_a, dn_a);
    wait_done(300);
    wait_n(3);
`ifdef DDR_RD_4K_SPLIT_EN
    chk("k4_ar_count", DDR_W'(ar_a.size()), DDR_W'(2));
    chk_ar(0, 32'h0000_0FC0, 0);
    chk_ar(1, 32'h0000_1000, 2);
`else
    chk("k4_ar_count", DDR_W'(ar_a.size()), DDR_W'(1));
    chk_ar(0, 32'h0000_0FC0, 3);
`endif
    add_exp(32'h0000_0FC0, 4);
    chk_stream("k4");

    // Reset in the middle of a 16-beat burst.
    clear_logs();
    send_cmd(32'h0006_0000, 16'd16, acc_a, dn_a);
    for (int i = 0; i < 200 && got.size() < 5; i++) @(negedge clk);
    chk("mid_reached_5_beats", DDR_W'(got.size() >= 5), DDR_W'(1));
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_ar_valid",  DDR_W'(ar_valid),  DDR_W'(0));
    chk("mid_rst_st_valid",  DDR_W'(st_valid),  DDR_W'(0));
    chk("mid_rst_cmd_ready", DDR_W'(cmd_ready), DDR_W'(1));
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    wait_n(2);
    clear_logs();
    send_cmd(32'h0007_0000, 16'd2, acc_a, dn_a);
    wait_done(300);
    wait_n(3);
    chk_ar(0, 32'h0007_0000, 1);
    add_exp(32'h0007_0000, 2);
    chk_stream("post_rst");

    wait_n(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
